dmem_arbiter: RTL

//   Round-robin arbiter sharing the single-port data memory between the CPU MEM stage (port 0)
//   and the program/data loader (port 1). One access per cycle; optional locked bursts so the

---
 rtl/dmem_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU (port 0) and the loader (port 1).
// Grants are combinational, one per cycle. A locked owner keeps the memory for up to MAX_BURST grants.
module dmem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  state_t            state;
  logic              ptr;      // 0: port0 wins a tie, 1: port1 wins a tie
  logic [CNT_W-1:0]  cnt;      // extra grants already given in the current locked burst
  logic              rv0, rv1;
  logic [DATA_W-1:0] rhold0, rhold1;
  logic              hold0, hold1;
  logic              g0, g1;

  assign hold0 = (state == OWN0) && m0_req && (cnt < CNT_LAST);
  assign hold1 = (state == OWN1) && m1_req && (cnt < CNT_LAST);

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (reset_n) begin
      if (hold0) begin
        g0 = 1'b1;
      end else if (hold1) begin
        g1 = 1'b1;
      end else if (m0_req && m1_req) begin
        g0 = ~ptr;
        g1 = ptr;
      end else begin
        g0 = m0_req;
        g1 = m1_req;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (g0) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (g1) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  assign mem_en = g0 | g1;
  assign m0_gnt = g0;
  assign m1_gnt = g1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      cnt    <= '0;
      rv0    <= 1'b0;
      rv1    <= 1'b0;
      rhold0 <= '0;
      rhold1 <= '0;
    end else begin
      rv0 <= g0 & ~m0_we;
      rv1 <= g1 & ~m1_we;
      if (rv0) rhold0 <= mem_rdata;
      if (rv1) rhold1 <= mem_rdata;
      if (g0) begin
        state <= m0_lock ? OWN0 : IDLE;
        ptr   <= 1'b1;
        cnt   <= hold0 ? cnt + 1'b1 : '0;
      end else if (g1) begin
        state <= m1_lock ? OWN1 : IDLE;
        ptr   <= 1'b0;
        cnt   <= hold1 ? cnt + 1'b1 : '0;
      end else begin
        // an owner that stops requesting gives up its lock
        state <= IDLE;
        cnt   <= '0;
      end
    end
  end

  // read data passes straight through in the response cycle and is held afterwards
  assign m0_rvalid = rv0;
  assign m1_rvalid = rv1;
  assign m0_rdata  = rv0 ? mem_rdata : rhold0;
  assign m1_rdata  = rv1 ? mem_rdata : rhold1;
  assign owner     = state;

endmodule
